// File: rtl/three_input_share_gen.sv
// Splits plain bits a/b/c into Boolean share pairs and supplies a fresh random bit rN,
// with all randomness drawn from an internal 16-bit Galois LFSR.
module three_input_share_gen #(
  parameter logic [15:0] SEED            = 16'hACE1,
  parameter int unsigned RESEED_INTERVAL = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_a,
  input  logic        in_b,
  input  logic        in_c,
  input  logic        seed_load,
  input  logic [15:0] seed_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        A0,
  output logic        A1,
  output logic        B0,
  output logic        B1,
  output logic        C0,
  output logic        C1,
  output logic        rN,
  output logic        reseed_req,
  output logic [15:0] tx_count
);

  localparam logic [15:0] POLY     = 16'hB400;
  localparam logic [15:0] INTERVAL = 16'(RESEED_INTERVAL);

  logic [15:0] lfsr;
  logic [15:0] lfsr_adv;
  logic [15:0] lfsr_next;
  logic [15:0] tx_inc;
  logic        accept;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  // Four serial steps per accept; the low poly nibble is zero so bits 3:0 are all fresh.
  always_comb lfsr_adv = lfsr_step(lfsr_step(lfsr_step(lfsr_step(lfsr))));

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    lfsr_next = lfsr;
    if (accept)
      lfsr_next = lfsr_adv;
    if (seed_load)
      lfsr_next = (seed_val == '0) ? SEED : seed_val;
  end

  always_comb tx_inc = (tx_count == '1) ? tx_count : tx_count + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr       <= SEED;
      tx_count   <= '0;
      reseed_req <= 1'b0;
    end else begin
      lfsr <= lfsr_next;
      if (seed_load) begin
        tx_count   <= '0;
        reseed_req <= 1'b0;
      end else if (accept) begin
        tx_count <= tx_inc;
        if (tx_inc == INTERVAL)
          reseed_req <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      A0 <= 1'b0;
      A1 <= 1'b0;
      B0 <= 1'b0;
      B1 <= 1'b0;
      C0 <= 1'b0;
      C1 <= 1'b0;
      rN <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      A0 <= in_a ^ lfsr[0];
      A1 <= lfsr[0];
      B0 <= in_b ^ lfsr[1];
      B1 <= lfsr[1];
      C0 <= in_c ^ lfsr[2];
      C1 <= lfsr[2];
      rN <= lfsr[3];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/three_input_share_gen.md
Name: three_input_share_gen

Overview:
- Masking front end that sits directly upstream of the masked three-input AND stage.
- Takes plain bits a/b/c with a valid/ready handshake and splits each into two Boolean shares.
- Supplies the fresh random bit rN that the AND stage consumes; all mask and rN bits come from an internal 16-bit Galois LFSR.
- Output is one registered transaction with a valid/ready handshake. A counter raises a reseed request after a programmable number of transactions.

Parameters:
- SEED, 16'hACE1, LFSR reset value. Also substituted whenever a zero seed is loaded. Must be nonzero.
- RESEED_INTERVAL, 1024, accepted transactions before reseed_req asserts (1..65535).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept
- in_a  in  1  plain operand A
- in_b  in  1  plain operand B
- in_c  in  1  plain operand C
- seed_load  in  1  load LFSR from seed_val on this edge
- seed_val  in  16  new LFSR seed
- out_valid  out  1  shares valid
- out_ready  in  1  downstream accepts
- A0, A1, B0, B1, C0, C1  out  1 each  share pairs
- rN  out  1  fresh random bit for the downstream recombination
- reseed_req  out  1  interval reached, reseed wanted
- tx_count  out  16  accepted transactions since reset or last seed_load

Behaviour:
- Reset (async, rst=1):
  - lfsr=SEED, out_valid=0, all shares and rN=0, tx_count=0, reseed_req=0.
  - Takes effect immediately, including mid-transaction. Any pending output is discarded.
- LFSR step (Galois, poly 16'hB400): if s[0]=1 then s'=(s>>1)^16'hB400, else s'=s>>1.
- Per accepted transaction:
  - Masks are taken from the current state: mA=s[0], mB=s[1], mC=s[2], r=s[3].
  - The LFSR then advances exactly 4 steps in that single cycle. This is equivalent to serial stepping, because bits 3:0 of the polynomial are 0.
  - The LFSR does not advance on cycles without an accept.
- Share encoding, registered on accept:
  - A0=in_a^mA, A1=mA; B0=in_b^mB, B1=mB; C0=in_c^mC, C1=mC; rN=r.
  - Invariant: X0^X1 equals the plain bit for every operand.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
  - Latency is 1 cycle: accepted at edge N, out_valid=1 after edge N.
  - Full throughput with out_ready held at 1.
  - When out_valid=1 and out_ready=0, all outputs hold stable and in_ready=0.
  - out_valid clears on a downstream take with no new accept. Take and accept in the same cycle keep out_valid=1 with the new data.
- Seed load:
  - On seed_load=1: lfsr <= (seed_val==0 ? SEED : seed_val), tx_count <= 0, reseed_req <= 0.
  - If an accept occurs in the same cycle, its masks use the pre-load state and the seed value wins for the next state. tx_count goes to 0; that accept is not counted.
- Counter:
  - tx_count increments on each accept and saturates at 16'hFFFF.
  - reseed_req sets on the accept that makes tx_count reach RESEED_INTERVAL and stays set until seed_load or rst.
  - The block keeps operating while reseed_req=1.
- LFSR never reaches 0, since a zero seed is substituted.

Test Plan:
- Reset, SEED=16'hACE1, accept a=1,b=1,c=0 with out_ready=1:
  - Next cycle: A0=0,A1=1, B0=1,B1=0, C0=0,C1=0, rN=0, out_valid=1. Internal lfsr=16'h1C4E.
  - Second accept a=0,b=0,c=1 gives A0=0,A1=0, B0=1,B1=1, C0=0,C1=1, rN=1.
- Backpressure, out_ready=0 for 5 cycles with in_valid=1:
  - in_ready=0 and outputs frozen; lfsr does not advance.
  - Release gives one output per cycle thereafter, with no loss or duplication.
- Random 10k transactions with random out_ready:
  - Every output has A0^A1=a, B0^B1=b, C0^C1=c.
  - rN sequence matches the software LFSR model bit-exactly.
- seed_load with seed_val=0 in the same cycle as an accept:
  - Emitted masks come from the old state; lfsr=16'hACE1 next; tx_count=0.
- RESEED_INTERVAL=4: after 4 accepts, reseed_req=1 and tx_count=4. It stays set through further accepts and clears the cycle after seed_load.
- rst pulse while out_valid=1 and out_ready=0: outputs immediately 0, out_valid=0, lfsr=SEED, and in_ready=1 after release.
